// File: rtl/capture_controller.sv
// -----------------------------------------------------------------------------
// capture_controller
//
// Acquisition stage behind the trigger detector. Keeps a circular sample
// buffer, fills a pretrigger window while armed, records the post-trigger
// samples after a detector pulse (or a software trigger), then streams the
// whole record out through a valid/ready port.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   start             arm request pulse; latches pretrig_len / total_len
//   abort             return to IDLE next cycle; beats every other input
//   pretrig_len       samples kept before the trigger sample
//   total_len         record length including the trigger sample
//   sample_in         trigger-source sample
//   sample_ena        sample_in valid this cycle
//   triggered         one-cycle pulse from the detector
//   force_trigger     software trigger, same effect as triggered
//   armed             high while waiting for a trigger
//   done              record complete and readable (held through readout)
//   trigger_addr      buffer address of the trigger sample
//   rd_start          begin readout; honoured only once the record is done
//   rd_data           readout sample
//   rd_valid          rd_data valid
//   rd_ready          consumer accepts
//   rd_last           final record sample, qualified by rd_valid
//   state_dbg         current FSM state encoding
//
// Readout handshake: a sample transfers on every rising edge where rd_valid
// and rd_ready are both high. While rd_valid is high and rd_ready is low,
// rd_data and rd_last hold their values.
// -----------------------------------------------------------------------------
module capture_controller #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] pretrig_len,
   input  logic [ADDR_WIDTH:0]   total_len,
   input  logic [DATA_WIDTH-1:0] sample_in,
   input  logic                  sample_ena,
   input  logic                  triggered,
   input  logic                  force_trigger,
   output logic                  armed,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] trigger_addr,
   input  logic                  rd_start,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic                  rd_last,
   output logic [2:0]            state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_WAIT = 3'd2,
      S_POST = 3'd3,
      S_DONE = 3'd4,
      S_READ = 3'd5
   } state_t;

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   TWO_L   = (ADDR_WIDTH+1)'(2);
   localparam logic [ADDR_WIDTH:0]   ONE_L   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

   state_t state, state_next;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] mem_q;

   logic [ADDR_WIDTH:0]   cfg_total;
   logic [ADDR_WIDTH-1:0] cfg_pre;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] pre_cnt;
   logic [ADDR_WIDTH:0]   post_cnt;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   issue_cnt;

   // Read pipeline stage between the RAM output register and rd_data.
   logic s1_valid;
   logic s1_last;

   // Clamped configuration, computed from the live inputs.
   logic [ADDR_WIDTH:0]   tl_clamp;
   logic [ADDR_WIDTH:0]   pre_limit;
   logic [ADDR_WIDTH-1:0] pre_clamp;
   logic [ADDR_WIDTH:0]   post_len;

   // Control strobes from the FSM.
   logic latch_cfg;
   logic do_write;
   logic take_trig;
   logic begin_read;
   logic out_adv;
   logic issue;
   logic trig_in;

   assign state_dbg = state;

   always_comb begin
      tl_clamp = total_len;
      if (total_len < TWO_L) begin
         tl_clamp = TWO_L;
      end else if (total_len > DEPTH_L) begin
         tl_clamp = DEPTH_L;
      end
      pre_limit = tl_clamp - TWO_L;
      pre_clamp = pretrig_len;
      if ({1'b0, pretrig_len} > pre_limit) begin
         pre_clamp = pre_limit[ADDR_WIDTH-1:0];
      end
   end

   // Never below 1 because the pretrigger window is capped at total-2.
   assign post_len = cfg_total - {1'b0, cfg_pre} - ONE_L;

   always_comb begin
      state_next = state;
      latch_cfg  = 1'b0;
      do_write   = 1'b0;
      take_trig  = 1'b0;
      begin_read = 1'b0;
      issue      = 1'b0;
      trig_in    = triggered | force_trigger;
      out_adv    = !rd_valid || rd_ready;
      if (abort) begin
         state_next = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  latch_cfg  = 1'b1;
                  state_next = (pre_clamp == '0) ? S_WAIT : S_PRE;
               end
            end
            S_PRE: begin
               if (sample_ena) begin
                  do_write = 1'b1;
                  if (pre_cnt + ONE_A == cfg_pre) begin
                     state_next = S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               do_write = sample_ena;
               if (trig_in) begin
                  take_trig = 1'b1;
                  // A sample arriving with the trigger is the first post
                  // sample; with a one-sample post window it ends the record.
                  if (sample_ena && post_len == ONE_L) begin
                     state_next = S_DONE;
                  end else begin
                     state_next = S_POST;
                  end
               end
            end
            S_POST: begin
               if (sample_ena) begin
                  do_write = 1'b1;
                  if (post_cnt == ONE_L) begin
                     state_next = S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (start) begin
                  latch_cfg  = 1'b1;
                  state_next = (pre_clamp == '0) ? S_WAIT : S_PRE;
               end else if (rd_start) begin
                  begin_read = 1'b1;
                  state_next = S_READ;
               end
            end
            S_READ: begin
               // Fetch a new RAM word whenever stage 1 is empty or will move
               // into the output register this cycle.
               issue = (issue_cnt != '0) && (!s1_valid || out_adv);
               if (rd_valid && rd_ready && rd_last) begin
                  state_next = S_IDLE;
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         armed        <= 1'b0;
         done         <= 1'b0;
         trigger_addr <= '0;
         rd_data      <= '0;
         rd_valid     <= 1'b0;
         rd_last      <= 1'b0;
         cfg_total    <= '0;
         cfg_pre      <= '0;
         wr_ptr       <= '0;
         pre_cnt      <= '0;
         post_cnt     <= '0;
         rd_ptr       <= '0;
         issue_cnt    <= '0;
         s1_valid     <= 1'b0;
         s1_last      <= 1'b0;
      end else begin
         state <= state_next;
         armed <= (state_next == S_WAIT);
         done  <= (state_next == S_DONE) || (state_next == S_READ);

         if (latch_cfg) begin
            cfg_total <= tl_clamp;
            cfg_pre   <= pre_clamp;
            wr_ptr    <= '0;
            pre_cnt   <= '0;
         end

         if (do_write) begin
            wr_ptr <= wr_ptr + ONE_A;
            if (state == S_PRE) begin
               pre_cnt <= pre_cnt + ONE_A;
            end
            if (state == S_POST) begin
               post_cnt <= post_cnt - ONE_L;
            end
         end

         if (take_trig) begin
            // The detector lags by one sample: the trigger sample is the
            // newest one written before this cycle.
            trigger_addr <= wr_ptr - ONE_A;
            post_cnt     <= sample_ena ? (post_len - ONE_L) : post_len;
         end

         if (begin_read) begin
            rd_ptr    <= trigger_addr - cfg_pre;
            issue_cnt <= cfg_total;
         end

         if (abort) begin
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            s1_valid  <= 1'b0;
            issue_cnt <= '0;
         end else if (state == S_READ) begin
            if (out_adv) begin
               rd_valid <= s1_valid;
               rd_last  <= s1_valid & s1_last;
               if (s1_valid) begin
                  rd_data <= mem_q;
               end
            end
            if (issue) begin
               s1_valid  <= 1'b1;
               s1_last   <= (issue_cnt == ONE_L);
               rd_ptr    <= rd_ptr + ONE_A;
               issue_cnt <= issue_cnt - ONE_L;
            end else if (out_adv) begin
               s1_valid <= 1'b0;
            end
         end
      end
   end

   // Sample buffer: synchronous write, registered read enabled only on issue
   // so that mem_q holds while the read pipeline is stalled.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr] <= sample_in;
      end
      if (issue) begin
         mem_q <= mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_capture_controller.sv
module tb_capture_controller;
   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic [AW-1:0] pretrig_len;
   logic [AW:0]   total_len;
   logic [DW-1:0] sample_in;
   logic          sample_ena;
   logic          triggered;
   logic          force_trigger;
   logic          armed;
   logic          done;
   logic [AW-1:0] trigger_addr;
   logic          rd_start;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_ready;
   logic          rd_last;
   logic [2:0]    state_dbg;

   int errors = 0;
   int checks = 0;

   // Scoreboard: expected record in readout order.
   logic [DW-1:0] exp_q[$];
   logic [AW-1:0] exp_taddr;
   int            exp_tl;
   int            ramp;

   always #5 clk = ~clk;

   capture_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .pretrig_len(pretrig_len), .total_len(total_len),
      .sample_in(sample_in), .sample_ena(sample_ena),
      .triggered(triggered), .force_trigger(force_trigger),
      .armed(armed), .done(done), .trigger_addr(trigger_addr),
      .rd_start(rd_start), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_ready(rd_ready), .rd_last(rd_last), .state_dbg(state_dbg)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) step();
         sample_ena = 1'b1;
         sample_in  = DW'(ramp);
         ramp++;
         step();
         sample_ena = 1'b0;
      end
   endtask

   // Arms a capture, feeds n_before samples (values 0..n_before-1), triggers,
   // then feeds the post samples plus two that must be ignored.
   task automatic do_capture(input int pre, input int tot, input int n_before,
                             input bit with_sample, input int early,
                             input int kind, input bit gaps, input string name);
      int tl, pt, post, remaining;
      tl   = (tot < 2) ? 2 : ((tot > DEPTH) ? DEPTH : tot);
      pt   = (pre > tl - 2) ? tl - 2 : pre;
      post = tl - pt - 1;
      exp_tl = tl;
      exp_q.delete();
      for (int v = n_before - 1 - pt; v <= n_before - 1 + post; v++) exp_q.push_back(DW'(v));
      exp_taddr = AW'(n_before - 1);
      ramp = 0;

      pretrig_len = AW'(pre);
      total_len   = (AW+1)'(tot);
      start = 1'b1;
      step();
      start = 1'b0;

      if (early >= 0) begin
         feed(early, gaps);
         triggered = 1'b1;
         step();
         triggered = 1'b0;
         feed(n_before - early, gaps);
      end else begin
         feed(n_before, gaps);
      end

      checks++;
      if (armed !== 1'b1) begin
         errors++;
         $display("FAIL %s armed_before_trig: got %b expected 1", name, armed);
      end

      triggered     = (kind != 1);
      force_trigger = (kind != 0);
      if (with_sample) begin
         sample_ena = 1'b1;
         sample_in  = DW'(ramp);
         ramp++;
      end
      step();
      triggered = 1'b0;
      force_trigger = 1'b0;
      sample_ena = 1'b0;

      checks++;
      if (trigger_addr !== exp_taddr) begin
         errors++;
         $display("FAIL %s trigger_addr: got %0d expected %0d", name, trigger_addr, exp_taddr);
      end
      checks++;
      if (armed !== 1'b0) begin
         errors++;
         $display("FAIL %s armed_after_trig: got %b expected 0", name, armed);
      end

      remaining = post - (with_sample ? 1 : 0);
      if (remaining > 0) begin
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_early: got %b expected 0", name, done);
         end
         feed(remaining, gaps);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s done_set: got %b expected 1", name, done);
      end
      feed(2, gaps);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s done_hold: got %b expected 1", name, done);
      end
   endtask

   // mode 0: rd_ready high; 1: pattern 1,0,0,1; 2: random
   task automatic do_readout(input int mode, input string name);
      int idx, cyc;
      bit rdy, stalled;
      logic [DW-1:0] held;
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s valid_lat1: got %b expected 0", name, rd_valid);
      end
      step();
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s valid_lat2: got %b expected 0", name, rd_valid);
      end
      step();
      checks++;
      if (rd_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s first_valid: got %b expected 1", name, rd_valid);
      end

      idx = 0;
      cyc = 0;
      stalled = 1'b0;
      held = '0;
      while (idx < exp_tl && cyc < 200) begin
         case (mode)
            0: rdy = 1'b1;
            1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         rd_ready = rdy;
         checks++;
         if (rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s bubble: rd_valid got %b expected 1 at sample %0d", name, rd_valid, idx);
         end else begin
            checks++;
            if (rd_data !== exp_q[0]) begin
               errors++;
               $display("FAIL %s rd_data: got %0d expected %0d at sample %0d", name, rd_data, exp_q[0], idx);
            end
            checks++;
            if (rd_last !== (exp_q.size() == 1)) begin
               errors++;
               $display("FAIL %s rd_last: got %b expected %b at sample %0d", name, rd_last, (exp_q.size() == 1), idx);
            end
            if (stalled) begin
               checks++;
               if (rd_data !== held) begin
                  errors++;
                  $display("FAIL %s stall_hold: got %0d expected %0d", name, rd_data, held);
               end
            end
            if (rdy) begin
               void'(exp_q.pop_front());
               idx++;
            end
         end
         held = rd_data;
         stalled = (rd_valid === 1'b1) && !rdy;
         step();
         cyc++;
      end
      rd_ready = 1'b0;
      checks++;
      if (idx != exp_tl) begin
         errors++;
         $display("FAIL %s delivered: got %0d expected %0d", name, idx, exp_tl);
      end
      checks++;
      if (rd_valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s end_idle: rd_valid=%b done=%b expected 0 0", name, rd_valid, done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 0; abort = 0; pretrig_len = 0; total_len = 0; sample_in = 0;
      sample_ena = 0; triggered = 0; force_trigger = 0; rd_start = 0; rd_ready = 0;
      step();
      step();
      reset = 1'b0;
      step();
      checks++;
      if ({armed, done, rd_valid, rd_last} !== 4'b0000 || trigger_addr !== '0 || rd_data !== '0) begin
         errors++;
         $display("FAIL reset_state: armed=%b done=%b valid=%b last=%b taddr=%0d data=%0d expected all 0",
                  armed, done, rd_valid, rd_last, trigger_addr, rd_data);
      end
   endtask

   task automatic test_basic();
      do_capture(4, 10, 21, 1'b0, -1, 0, 1'b0, "basic");
      do_readout(0, "basic");
   endtask

   task automatic test_trig_in_pre();
      do_capture(8, 12, 13, 1'b0, 3, 0, 1'b0, "trig_in_pre");
      do_readout(0, "trig_in_pre");
   endtask

   task automatic test_full_wrap();
      do_capture(14, 16, 31, 1'b0, -1, 1, 1'b0, "full_depth");
      do_readout(0, "full_depth");
      do_capture(14, 16, 35, 1'b0, -1, 2, 1'b0, "full_wrap");
      do_readout(0, "full_wrap");
   endtask

   task automatic test_trig_with_sample();
      do_capture(2, 4, 9, 1'b1, -1, 0, 1'b0, "trig_with_sample");
      do_readout(0, "trig_with_sample");
   endtask

   task automatic test_backpressure_clamp();
      do_capture(3, 10, 12, 1'b0, -1, 0, 1'b1, "backpressure");
      do_readout(1, "backpressure");
      do_capture(3, 0, 5, 1'b0, -1, 0, 1'b0, "clamp_total0");
      do_readout(1, "clamp_total0");
      do_capture(5, 4, 6, 1'b0, -1, 0, 1'b0, "clamp_pre");
      do_readout(1, "clamp_pre");
      do_capture(2, 25, 20, 1'b1, -1, 1, 1'b1, "clamp_total_hi");
      do_readout(2, "clamp_total_hi");
   endtask

   task automatic test_back_to_back();
      do_capture(3, 8, 10, 1'b0, -1, 0, 1'b0, "rearm_first");
      do_capture(2, 6, 7, 1'b1, -1, 2, 1'b1, "rearm_second");
      do_readout(2, "rearm_second");
   endtask

   task automatic test_abort_reset();
      ramp = 0;
      pretrig_len = 4;
      total_len = 10;
      start = 1'b1;
      step();
      start = 1'b0;
      feed(21, 1'b0);
      triggered = 1'b1;
      step();
      triggered = 1'b0;
      feed(2, 1'b0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++;
      if ({armed, done, rd_valid} !== 3'b000) begin
         errors++;
         $display("FAIL abort_status: armed=%b done=%b valid=%b expected 0 0 0", armed, done, rd_valid);
      end
      checks++;
      if (trigger_addr !== 4'd4) begin
         errors++;
         $display("FAIL abort_taddr_kept: got %0d expected 4", trigger_addr);
      end
      feed(4, 1'b0);
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      step();
      step();
      step();
      checks++;
      if (done !== 1'b0 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_ignores: done=%b rd_valid=%b expected 0 0", done, rd_valid);
      end

      // start together with abort must not arm
      pretrig_len = 0;
      total_len = 4;
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      feed(3, 1'b0);
      checks++;
      if (armed !== 1'b0) begin
         errors++;
         $display("FAIL start_with_abort: armed got %b expected 0", armed);
      end

      // reset in the middle of a readout
      do_capture(4, 10, 21, 1'b0, -1, 0, 1'b0, "pre_reset");
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      step();
      step();
      rd_ready = 1'b1;
      step();
      step();
      rd_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({armed, done, rd_valid, rd_last} !== 4'b0000 || trigger_addr !== '0 || rd_data !== '0) begin
         errors++;
         $display("FAIL async_reset: armed=%b done=%b valid=%b last=%b taddr=%0d data=%0d expected all 0",
                  armed, done, rd_valid, rd_last, trigger_addr, rd_data);
      end
      step();
      reset = 1'b0;
      step();
      do_capture(4, 10, 21, 1'b0, -1, 0, 1'b0, "after_reset");
      do_readout(0, "after_reset");
   endtask

   task automatic test_random();
      int tot, pre, tl, pt, nb;
      for (int it = 0; it < 8; it++) begin
         tot = $urandom_range(0, 31);
         pre = $urandom_range(0, 15);
         tl  = (tot < 2) ? 2 : ((tot > DEPTH) ? DEPTH : tot);
         pt  = (pre > tl - 2) ? tl - 2 : pre;
         nb  = pt + 1 + $urandom_range(0, 12);
         do_capture(pre, tot, nb, 1'($urandom_range(0, 1)), -1,
                    $urandom_range(0, 2), 1'b1, "random");
         do_readout($urandom_range(0, 2), "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_trig_in_pre();
      test_full_wrap();
      test_trig_with_sample();
      test_backpressure_clamp();
      test_back_to_back();
      test_abort_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/capture_controller.md
# capture_controller

Acquisition stage directly downstream of the trigger detector. Owns a circular sample buffer, keeps a configurable pretrigger window while armed, records post-trigger samples after the detector's `triggered` pulse (or a forced trigger), then streams the captured record to the readout path through a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 8, sample width
- `ADDR_WIDTH`, 8, buffer address width; DEPTH = 2^ADDR_WIDTH
- `clk` in 1, clock
- `reset` in 1, asynchronous, active-high
- `start` in 1, arm request pulse; latches configuration
- `abort` in 1, return to IDLE; has priority over every other input
- `pretrig_len` in ADDR_WIDTH, samples kept before the trigger sample
- `total_len` in ADDR_WIDTH+1, record length including the trigger sample
- `sample_in` in DATA_WIDTH, trigger-source sample
- `sample_ena` in 1, `sample_in` valid this cycle
- `triggered` in 1, one-cycle pulse from the detector
- `force` in 1, software trigger, equivalent to `triggered`
- `armed` out 1, high in WAIT
- `done` out 1, record complete, readable
- `trigger_addr` out ADDR_WIDTH, buffer address of the trigger sample
- `rd_start` in 1, begin readout; honoured only in DONE
- `rd_data` out DATA_WIDTH, readout sample
- `rd_valid` out 1, `rd_data` valid
- `rd_ready` in 1, consumer accepts
- `rd_last` out 1, marks the final record sample, qualified by `rd_valid`

## Operation
- States: IDLE, PRE, WAIT, POST, DONE, READ.
- Configuration is latched on an accepted `start`:
  - `total_len` is clamped to [2, DEPTH].
  - `pretrig_len` is clamped to at most total_len-2.
  - post_len = total_len - pretrig_len - 1, always ≥ 1.
- IDLE:
  - `start` → PRE, clearing the write pointer and counters.
  - If latched `pretrig_len`=0, `start` goes directly to WAIT.
- PRE:
  - Each `sample_ena` writes `mem[wr_ptr]` and increments `wr_ptr` modulo DEPTH.
  - After the write that makes pre_cnt == pretrig_len → WAIT.
  - `triggered` and `force` are ignored.
- WAIT:
  - Writing continues circularly.
  - On `triggered|force`:
    - `trigger_addr` ← wr_ptr-1 (mod DEPTH), i.e. the newest sample written before this cycle. The detector has one sample of latency.
    - → POST with post counter = post_len.
    - A `sample_ena` in the trigger cycle is written and counts as the first post sample.
- POST:
  - Each write decrements the post counter.
  - The write taking it to 0 → DONE. No further writes occur.
- DONE:
  - `done`=1.
  - `start` re-arms, discarding the record.
  - `rd_start` → READ with rd_ptr = trigger_addr - pretrig_len (mod DEPTH).
- READ:
  - Emits `total_len` samples in address order, wrapping modulo DEPTH.
  - `rd_data` and `rd_last` hold stable while `rd_valid` && !`rd_ready`.
  - After the `rd_last` handshake → IDLE, `done` cleared.
- `sample_ena` is ignored in IDLE, DONE and READ.
- `abort` in any state → IDLE next cycle. Clears `armed`, `done` and `rd_valid`; `trigger_addr` is kept.

## Timing
- Reset: state IDLE; `armed`, `done`, `rd_valid`, `rd_last` = 0; `trigger_addr`, `rd_data` = 0. Buffer contents are not reset.
- All outputs are registered.
- `armed` rises the cycle after the WAIT-entering edge and falls the cycle after the trigger edge.
- `done` rises the cycle after the final POST write.
- Buffer write is synchronous; read has 1-cycle latency.
- First `rd_valid` occurs exactly 2 cycles after the `rd_start` edge.
- With `rd_ready` held high, throughput is 1 sample/cycle with no bubbles, including across the address wrap.
- Back-pressure inserts no extra bubble once `rd_ready` returns.
- Simultaneous events:
  - `start` with `abort` → IDLE.
  - `triggered` with `force` → a single trigger.
  - `rd_start` outside DONE is ignored.
- Reset mid-READ or mid-POST: immediate IDLE. Next `start` behaves as from power-up.

## Test plan
All scenarios use ADDR_WIDTH=4, DEPTH 16, ramp samples 0,1,2,… one per `sample_ena`.
- **Basic capture.** pretrig 4, total 10; `triggered` pulses after sample 20 is written.
  - Expect `trigger_addr`=4.
  - Readout 16..25, `rd_last` on 25, then IDLE.
- **Trigger during PRE ignored.** pretrig 8; `triggered` after sample 3, then again after sample 12.
  - Expect `trigger_addr`=12.
  - Readout starts at 4.
- **Full depth with wrap.** total 16, pretrig 14; trigger after sample 30.
  - Readout 16..31 with no bubbles under constant `rd_ready`.
  - Wrap from address 15→0 is seamless.
- **Trigger coinciding with sample_ena.** pretrig 2, total 4; `triggered` and sample 9 arrive in the same cycle.
  - Expect `trigger_addr` = address of 8.
  - 9 counts as the post sample; readout 6,7,8,9.
- **Back-pressure and clamping.** `rd_ready` toggles 1,0,0,1 repeatedly.
  - Every sample is delivered exactly once, with `rd_data` stable while stalled.
  - Clamping: total_len=0 gives total 2; pretrig 5 with total 4 gives pretrig 2.
- **Abort and reset.** `abort` mid-POST, then reset mid-READ.
  - After `abort`: IDLE next cycle with all status low.
  - After reset: asynchronous clear of all status.
  - A fresh capture afterwards matches the basic-capture result.
